// File: rtl/ccs_out_wait_fifo.sv
// Transmit-side output port: a small circular FIFO between the core (d/ivld/irdy)
// and the external consumer (z/ovld/ordy). irdy, ovld and cnt come from state only.
module ccs_out_wait_fifo #(
   parameter int rscid = 1,
   parameter int width = 8,
   parameter int depth = 4,
   parameter int cntw  = $clog2(depth + 1)
) (
   input  logic             clk,
   input  logic             arst,
   input  logic [width-1:0] d,
   input  logic             ivld,
   output logic             irdy,
   output logic [width-1:0] z,
   output logic             ovld,
   input  logic             ordy,
   output logic [cntw-1:0]  cnt
);

   localparam int AW = $clog2(depth);

   // The resource ID only tags the instance; a negative one is meaningless.
   if (rscid < 0) begin : g_neg_rscid_unsupported
   end

   logic [width-1:0] mem_q [depth];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [cntw-1:0]  cnt_q, cnt_d;
   logic             push, pop;

   assign irdy = !arst && (cnt_q != cntw'(depth));
   assign ovld = (cnt_q != '0);
   assign z    = ovld ? mem_q[rptr_q] : '0;
   assign cnt  = cnt_q;

   assign push = ivld && irdy;
   assign pop  = ovld && ordy;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + cntw'(1);
         2'b01:   cnt_d = cnt_q - cntw'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage is deliberately left unreset; the counter masks stale entries.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= d;
   end

endmodule

// File: tb/tb_ccs_out_wait_fifo.sv
// Bench for ccs_out_wait_fifo: directed steps plus random traffic, checked against
// a queue model of the FIFO contents.
module tb_ccs_out_wait_fifo;

   localparam int DEPTH = 4;
   localparam int W     = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          arst;
   logic [W-1:0]  d;
   logic          ivld;
   logic          irdy;
   logic [W-1:0]  z;
   logic          ovld;
   logic          ordy;
   logic [CW-1:0] cnt;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] q[$];

   ccs_out_wait_fifo #(.rscid(1), .width(W), .depth(DEPTH)) dut (
      .clk(clk), .arst(arst), .d(d), .ivld(ivld), .irdy(irdy),
      .z(z), .ovld(ovld), .ordy(ordy), .cnt(cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_all(input string tag);
      logic [W-1:0] ez;
      ez = (q.size() != 0) ? q[0] : '0;
      chk({tag, ".ovld"}, W'(ovld), W'(q.size() != 0));
      chk({tag, ".z"},    z, ez);
      chk({tag, ".cnt"},  W'(cnt), W'(q.size()));
      chk({tag, ".irdy"}, W'(irdy), W'(!arst && q.size() != DEPTH));
   endtask

   // One clock: drive after the falling edge, check pre-edge, update model, check post-edge.
   task automatic cyc(input string tag, input logic v, input logic [W-1:0] dd, input logic r);
      bit do_push, do_pop;
      @(negedge clk);
      ivld = v; d = dd; ordy = r;
      #1;
      chk_all({tag, ".pre"});
      do_push = v && !arst && (q.size() != DEPTH);
      do_pop  = r && (q.size() != 0);
      @(posedge clk);
      #1;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(dd);
      chk_all({tag, ".post"});
   endtask

   initial begin
      arst = 1'b1; ivld = 1'b1; d = 8'hA5; ordy = 1'b0;
      // Reset held across edges with a write pending: nothing may be accepted.
      repeat (2) @(posedge clk);
      #1;
      chk_all("rst");
      @(negedge clk);
      arst = 1'b0; ivld = 1'b0;
      #1;
      chk_all("rel");

      // Single word, consumer stalled for five cycles.
      cyc("single_push", 1'b1, 8'h3C, 1'b0);
      chk("single_z", z, 8'h3C);
      for (int i = 0; i < 5; i++) cyc("stall", 1'b0, 8'h00, 1'b0);
      chk("stall_z", z, 8'h3C);
      cyc("single_pop", 1'b0, 8'h00, 1'b1);

      // Fill to full, rejected write, then drain in order.
      for (int i = 1; i <= 4; i++) cyc("fill", 1'b1, W'(i), 1'b0);
      chk("full_cnt", W'(cnt), 8'd4);
      cyc("full_reject", 1'b1, 8'h05, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         chk("drain_z", z, W'(i));
         cyc("drain", 1'b0, 8'h00, 1'b1);
      end
      chk("drained_ovld", W'(ovld), 8'd0);

      // Full with simultaneous pop: only the pop happens.
      for (int i = 0; i < 4; i++) cyc("refill", 1'b1, W'(8'h40 + i), 1'b0);
      cyc("full_pushpop", 1'b1, 8'h44, 1'b1);
      chk("full_pushpop_cnt", W'(cnt), 8'd3);
      cyc("after_full", 1'b1, 8'h44, 1'b0);
      chk("after_full_cnt", W'(cnt), 8'd4);
      for (int i = 0; i < 4; i++) cyc("drain2", 1'b0, 8'h00, 1'b1);

      // Streaming across pointer wrap.
      for (int i = 0; i < 20; i++) begin
         cyc("stream", 1'b1, W'(8'h10 + i), 1'b1);
         chk("stream_cnt", W'(cnt), 8'd1);
      end
      cyc("stream_tail", 1'b0, 8'h00, 1'b1);

      // Asynchronous reset in the middle of a cycle with three words held.
      for (int i = 0; i < 3; i++) cyc("pre_rst", 1'b1, W'(8'h60 + i), 1'b0);
      @(negedge clk);
      ivld = 1'b0; ordy = 1'b0;
      #2;
      arst = 1'b1;
      #1;
      q.delete();
      chk_all("midrst");
      @(negedge clk);
      arst = 1'b0;
      #1;
      chk_all("midrst_rel");
      cyc("post_rst_push", 1'b1, 8'h77, 1'b0);
      chk("post_rst_z", z, 8'h77);
      cyc("post_rst_pop", 1'b0, 8'h00, 1'b1);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         cyc("rand", 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
      for (int i = 0; i < DEPTH; i++) cyc("final_drain", 1'b0, 8'h00, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ccs_out_wait_fifo.md
# ccs_out_wait_fifo

Transmit-side I/O port for the PE top-level. The design core pushes words into a small FIFO through a valid/ready handshake, and the port drives them to the external consumer through its own valid/ready handshake. This is the registered, flow-controlled counterpart to the pass-through input port: it decouples core output timing from downstream stalls on the O/I/W address and data resources.

## Interface

Parameters:
- rscid, 1, resource ID; informational only, no effect on logic.
- width, 8, data word width in bits (≥1).
- depth, 4, FIFO entries; power of two, ≥2.
- cntw, $clog2(depth+1), width of the occupancy count.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- arst  in  1  asynchronous, active-high reset.
- d  in  width  write data from the core.
- ivld  in  1  core asserts when d is valid.
- irdy  out  1  port can accept a word.
- z  out  width  head-of-FIFO data to the consumer.
- ovld  out  1  z is valid.
- ordy  in  1  consumer accepts z.
- cnt  out  cntw  current occupancy, 0..depth.

## Operation

- Storage is circular: `depth` entries, a write pointer and a read pointer each log2(depth) bits wide, plus an occupancy counter of cntw bits.
- Pointers wrap modulo depth with no special case.
- **Push**: occurs when ivld && irdy. Writes d at the write pointer, then the write pointer increments.
- **Pop**: occurs when ovld && ordy. The read pointer increments.
- **Ready and valid**:
  - irdy = !arst && (cnt != depth). It depends only on state and reset, with no combinational path from ordy.
  - ovld = (cnt != 0). There is no combinational path from ivld.
- **z**: equals the entry at the read pointer when ovld = 1. It is forced to 0 when ovld = 0.
- **Counter update**:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged, both pointers advance
  - neither: unchanged
- **Full**: irdy = 0 even if ordy = 1 in the same cycle. A pop while full frees space for the next cycle only.
- **Empty**: a push does not bypass the storage. The word appears on z with ovld = 1 in the following cycle.
- **Write without ready**: ivld while irdy = 0 is ignored. No state changes, and the core must hold d and ivld.
- **Consumer stall**: ovld and z remain stable while ordy = 0. Stable means unchanged until a pop occurs.
- **Storage reset**: the memory array is not reset. Pointers and the counter are reset.
- **Reset mid-operation**: asserting arst discards all contents immediately (asynchronously). Outputs take reset values within the same cycle.
- **Ordering**: words leave in the order they were pushed. None are dropped or duplicated.

## Timing

- **Reset values** (while arst = 1 and after release until the first push):
  - ovld = 0
  - z = 0
  - cnt = 0
  - irdy = 0 while arst = 1; irdy = 1 from the first cycle after release
- **Latency**: push at edge N gives ovld = 1 and z = d after edge N. A word is therefore visible one cycle after acceptance.
- **Throughput**: one push and one pop per cycle sustained whenever 0 < cnt < depth.
- **Registered outputs**: cnt and ovld are derived from registers only.
- **z**: a mux of storage indexed by the registered read pointer, gated by ovld.
- **Reset release**: arst deassertion is synchronised externally. The block samples no input on the release edge other than normal operation.

## Test plan

- **Reset**: drive arst = 1 with ivld = 1 and d = 8'hA5 → ovld = 0, z = 0, cnt = 0, irdy = 0. After release with ivld = 0 → irdy = 1, cnt = 0.
- **Single word**: push 8'h3C at edge N with ordy = 0 → after N, ovld = 1, z = 8'h3C, cnt = 1. Hold ordy = 0 for 5 cycles → z stays 8'h3C. Pulse ordy → cnt = 0, ovld = 0, z = 0.
- **Fill to full** (depth = 4): push 8'h01..8'h04 with ordy = 0 → cnt = 4, irdy = 0. Attempt push of 8'h05 → ignored. Drain with ordy = 1 → z sequence 01, 02, 03, 04, then ovld = 0.
- **Full with simultaneous pop**: at cnt = 4 drive ivld = 1, ordy = 1 → only the pop occurs, cnt = 3. The next cycle's push is accepted and cnt returns to 4.
- **Streaming and wrap**: ivld = 1 and ordy = 1 continuously for 20 words 8'h10..8'h23 → cnt steady at 1 after the first cycle. Output order matches input exactly across pointer wrap.
- **Reset mid-stream**: with cnt = 3, assert arst mid-cycle → ovld, z and cnt go to 0 immediately. After release, push 8'h77 → it is the next word out; no stale data appears.
